// File: rtl/seq_mag_comp_if.sv
// Handshake and operand bundle for the sequential magnitude comparator.
// The master issues start with operands; the slave (comparator) returns status and result flags.
interface seq_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/seq_mag_comp.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, with early exit
// on the first differing digit and an optional two's-complement mode.
module seq_mag_comp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_mag_comp_if.slave    bus
);
    localparam int N     = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_mag_comp: WIDTH must be >= 1 and DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             accept, last, differ;
    logic             eq_r, gt_r, lt_r;

    // Operands shift left each SCAN cycle, so the digit under test is always at the top.
    assign dig_a  = a_sh[WIDTH-1 -: DIGIT];
    assign dig_b  = b_sh[WIDTH-1 -: DIGIT];
    assign differ = (dig_a != dig_b);
    assign last   = (idx == IDX_W'(N - 1));
    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (differ || last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SCAN);
        bus.done = (state == DONE);
        bus.eq   = eq_r;
        bus.gt   = gt_r;
        bus.lt   = lt_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            eq_r <= 1'b0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
        end else if (accept) begin
            idx  <= '0;
            eq_r <= 1'b0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
        end else if (state == SCAN) begin
            if (differ) begin
                gt_r <= (dig_a > dig_b);
                lt_r <= (dig_a < dig_b);
            end else if (last) begin
                eq_r <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
            b_sh <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
        end else if (state == SCAN) begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
        end
    end
endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench driving a DIGIT=1 and a DIGIT=4 comparator with the same operands.
module tb_seq_mag_comp;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] a, b;
    int         n_checks = 0;
    int         n_errors = 0;

    seq_mag_comp_if #(.WIDTH(8)) if1 ();
    seq_mag_comp_if #(.WIDTH(8)) if4 ();

    assign if1.start = start;  assign if1.signed_mode = signed_mode;
    assign if1.a     = a;      assign if1.b           = b;
    assign if4.start = start;  assign if4.signed_mode = signed_mode;
    assign if4.a     = a;      assign if4.b           = b;

    seq_mag_comp #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    seq_mag_comp #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] res1();
        return {if1.eq, if1.gt, if1.lt};
    endfunction

    function automatic logic [2:0] res4();
        return {if4.eq, if4.gt, if4.lt};
    endfunction

    // exp is {eq,gt,lt}; lat is the number of edges after the accepting edge until done shows.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input logic [2:0] exp, input int lat1,
                          input int lat4, input bit glitch);
        int         seen1 = 0, seen4 = 0, np1 = 0, np4 = 0;
        logic [2:0] r1 = 3'b000, r4 = 3'b000;
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, "_busy1"}, 32'(if1.busy), 32'd1);
        check({tag, "_busy4"}, 32'(if4.busy), 32'd1);
        check({tag, "_clr1"}, 32'(res1()), 32'd0);
        check({tag, "_clr4"}, 32'(res4()), 32'd0);
        a = ~av; b = ~bv; signed_mode = ~sm;
        for (int c = 1; c <= 10; c++) begin
            if (glitch && c == 1) start = 1'b1;
            cyc();
            start = 1'b0;
            if (if1.done) begin
                np1++; seen1 = c; r1 = res1();
                check({tag, "_busy_at_done1"}, 32'(if1.busy), 32'd0);
            end
            if (if4.done) begin
                np4++; seen4 = c; r4 = res4();
                check({tag, "_busy_at_done4"}, 32'(if4.busy), 32'd0);
            end
        end
        check({tag, "_lat1"}, 32'(seen1), 32'(lat1));
        check({tag, "_lat4"}, 32'(seen4), 32'(lat4));
        check({tag, "_pulses1"}, 32'(np1), 32'd1);
        check({tag, "_pulses4"}, 32'(np4), 32'd1);
        check({tag, "_res1"}, 32'(r1), 32'(exp));
        check({tag, "_res4"}, 32'(r4), 32'(exp));
        check({tag, "_hold1"}, 32'(res1()), 32'(exp));
        check({tag, "_hold4"}, 32'(res4()), 32'(exp));
    endtask

    initial begin
        int np1, np4;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        cyc(); cyc();
        check("rst_out1", {27'd0, if1.busy, if1.done, res1()}, 32'd0);
        check("rst_out4", {27'd0, if4.busy, if4.done, res4()}, 32'd0);
        rst = 1'b0;
        cyc();

        run_op("u80_7f",  8'h80, 8'h7F, 1'b0, 3'b010, 1, 1, 1'b0);
        run_op("s80_7f",  8'h80, 8'h7F, 1'b1, 3'b001, 1, 1, 1'b0);
        run_op("u5a_5a",  8'h5A, 8'h5A, 1'b0, 3'b100, 8, 2, 1'b0);
        run_op("u01_00",  8'h01, 8'h00, 1'b0, 3'b010, 8, 2, 1'b0);
        run_op("sff_00",  8'hFF, 8'h00, 1'b1, 3'b001, 1, 1, 1'b0);
        run_op("u3c_3d",  8'h3C, 8'h3D, 1'b0, 3'b001, 8, 2, 1'b0);
        run_op("u4c_3d",  8'h4C, 8'h3D, 1'b0, 3'b010, 2, 1, 1'b0);
        run_op("s3c_c3",  8'h3C, 8'hC3, 1'b1, 3'b010, 1, 1, 1'b0);
        run_op("glitch",  8'h5A, 8'h5A, 1'b0, 3'b100, 8, 2, 1'b1);

        // Reset lands on the edge E0+3 of an 8-digit compare.
        a = 8'h5A; b = 8'h5A; signed_mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_out1", {27'd0, if1.busy, if1.done, res1()}, 32'd0);
        check("midrst_out4", {27'd0, if4.busy, if4.done, res4()}, 32'd0);
        np1 = 0; np4 = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (if1.done) np1++;
            if (if4.done) np4++;
        end
        check("midrst_nodone1", 32'(np1), 32'd0);
        check("midrst_nodone4", 32'(np4), 32'd0);

        // Start coinciding with reset must not be accepted.
        a = 8'h80; b = 8'h7F; rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        check("rststart_busy1", 32'(if1.busy), 32'd0);
        check("rststart_busy4", 32'(if4.busy), 32'd0);
        cyc();
        check("rststart_done1", {30'd0, if1.busy, if1.done}, 32'd0);
        check("rststart_done4", {30'd0, if4.busy, if4.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
